pcpi_issue_ctrl: RTL and testbench

Sequencer that owns the handshake to the single PCPI coprocessor (fused matrix-multiply unit) in the TinyTapeout wrapper. Accepts a complete instruction plus two operands from the upstream nibble loader, drives the PCPI valid/insn/rs handshake, and optionally aborts a stalled coprocessor with a watchdog. It captures the write-back result and streams it out as eight 4-bit nibbles under a valid/ack handshake toward the pin-limited output bus.

---
 rtl/pcpi_ctrl_pkg.sv | 20 ++
 rtl/pcpi_nibble_tx.sv | 57 +++++
 rtl/pcpi_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pcpi_issue_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_ctrl_pkg.sv
// pcpi_ctrl_pkg
//   Shared types and constants for the PCPI issue sequencer:
//   - state_t  : sequencer states (IDLE / ISSUE / SEND)
//   - XLEN     : PCPI data and instruction width
//   - NIBBLES  : result nibbles streamed per write-back
//   - NIBBLE_W : width of one output nibble
package pcpi_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int NIBBLES  = 8;
  localparam int NIBBLE_W = 4;
  localparam int IDX_W    = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/pcpi_nibble_tx.sv
// pcpi_nibble_tx
//   Holds a captured 32-bit write-back result and streams it out LSB nibble
//   first under a valid/ack handshake.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   load           one-cycle strobe from the sequencer: capture load_data
//   load_data      result word to capture
//   res_ack        consumer takes the current nibble when res_valid is high
//   res_valid      a nibble is being presented
//   res_nibble     current nibble
//   res_last       presenting the final nibble
//   drained        combinational pulse: the final nibble is being acked
module pcpi_nibble_tx
  import pcpi_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [XLEN-1:0]     load_data,
  input  logic                res_ack,
  output logic                res_valid,
  output logic [NIBBLE_W-1:0] res_nibble,
  output logic                res_last,
  output logic                drained
);

  logic [XLEN-1:0]  result;
  logic [IDX_W-1:0] idx;
  logic             take;
  logic             at_last;

  assign at_last    = (idx == IDX_W'(NIBBLES - 1));
  assign take       = res_valid && res_ack;
  assign drained    = take && at_last;
  assign res_last   = res_valid && at_last;
  assign res_nibble = result[idx*NIBBLE_W +: NIBBLE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      idx       <= '0;
      res_valid <= 1'b0;
    end else if (load) begin
      result    <= load_data;
      idx       <= '0;
      res_valid <= 1'b1;
    end else if (take) begin
      if (at_last) begin
        idx       <= '0;
        res_valid <= 1'b0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl
//   Owns the handshake to the single PCPI coprocessor. Accepts one command
//   (insn + rs1 + rs2), issues it on PCPI, and streams any write-back result
//   out as eight nibbles through pcpi_nibble_tx.
//   Optional watchdog (define PCPI_TIMEOUT_EN): aborts an issue after
//   TIMEOUT_CYCLES consecutive cycles with neither pcpi_ready nor pcpi_wait.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             upstream command handshake
//   cmd_insn/cmd_rs1/cmd_rs2        command payload
//   pcpi_valid/insn/rs1/rs2         registered PCPI issue
//   pcpi_ready/wr/rd/wait           PCPI completion and stall
//   res_valid/nibble/last, res_ack  nibble output stream
//   done                            one-cycle retire pulse
//   err_timeout                     sticky abort flag, cleared on next accept
module pcpi_issue_ctrl
  import pcpi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [XLEN-1:0]     cmd_insn,
  input  logic [XLEN-1:0]     cmd_rs1,
  input  logic [XLEN-1:0]     cmd_rs2,
  output logic                pcpi_valid,
  output logic [XLEN-1:0]     pcpi_insn,
  output logic [XLEN-1:0]     pcpi_rs1,
  output logic [XLEN-1:0]     pcpi_rs2,
  input  logic                pcpi_ready,
  input  logic                pcpi_wr,
  input  logic [XLEN-1:0]     pcpi_rd,
  input  logic                pcpi_wait,
  output logic                res_valid,
  output logic [NIBBLE_W-1:0] res_nibble,
  output logic                res_last,
  input  logic                res_ack,
  output logic                done,
  output logic                err_timeout
);

  state_t state, state_d;
  logic   accept;
  logic   tx_load;
  logic   drained;
  logic   done_d;

  // The retire cycle is spent in IDLE with done high; new commands are only
  // taken from the following cycle.
  assign cmd_ready = (state == IDLE) && !done;
  assign accept    = cmd_valid && cmd_ready;

`ifdef PCPI_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 3) ? 3 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             abort;
`else
  logic unused_wd;
  assign unused_wd   = pcpi_wait ^ TIMEOUT_CYCLES[0];
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    tx_load = 1'b0;
    done_d  = 1'b0;
`ifdef PCPI_TIMEOUT_EN
    cnt_d   = cnt;
    abort   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
`ifdef PCPI_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        // pcpi_ready takes priority over a coincident watchdog expiry.
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            tx_load = 1'b1;
            state_d = SEND;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
`ifdef PCPI_TIMEOUT_EN
        else if (pcpi_wait) begin
          cnt_d = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      SEND: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcpi_valid <= 1'b0;
      done       <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
    end else begin
      state      <= state_d;
      pcpi_valid <= (state_d == ISSUE);
      done       <= done_d;
      if (accept) begin
        pcpi_insn <= cmd_insn;
        pcpi_rs1  <= cmd_rs1;
        pcpi_rs2  <= cmd_rs2;
      end
    end
  end

`ifdef PCPI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (accept)     err_timeout <= 1'b0;
      else if (abort) err_timeout <= 1'b1;
    end
  end
`endif

  pcpi_nibble_tx u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_load),
    .load_data  (pcpi_rd),
    .res_ack    (res_ack),
    .res_valid  (res_valid),
    .res_nibble (res_nibble),
    .res_last   (res_last),
    .drained    (drained)
  );

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// tb_pcpi_issue_ctrl
//   Transaction-level bench: each command is described by its payload, the
//   cycle at which the coprocessor answers, a wait pattern, per-nibble
//   consumer stalls and an optional reset point. Expected behaviour is worked
//   out per cycle from those parameters (run length of non-wait cycles for
//   the watchdog, shifted result for nibbles).
module tb_pcpi_issue_ctrl;

  localparam int TO = 8;
`ifdef PCPI_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_ready, pcpi_wr, pcpi_wait;
  logic [31:0] pcpi_rd;
  logic        res_valid, res_last, res_ack, done, err_timeout;
  logic [3:0]  res_nibble;

  int n_chk = 0;
  int n_err = 0;
  int stall [8];

  always #5 clk = ~clk;

  pcpi_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait),
    .res_valid(res_valid), .res_nibble(res_nibble), .res_last(res_last),
    .res_ack(res_ack), .done(done), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // wmode: 0 never wait, 1 random wait, 2 wait for the first 20 cycles
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int rdy_dly, input bit wr,
                         input logic [31:0] rd, input int wmode, input int rst_nib);
    int         run;
    bit         aborted;
    bit         w;
    logic [3:0] e;
    run     = 0;
    aborted = 1'b0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
    step;
    cmd_valid = 1'b0; cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
    chk("issue_valid", pcpi_valid, 1);
    chk("issue_insn", pcpi_insn, insn);
    chk("issue_rs1", pcpi_rs1, rs1);
    chk("issue_rs2", pcpi_rs2, rs2);
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("err_cleared", err_timeout, 0);

    for (int j = 0; j <= rdy_dly; j++) begin
      case (wmode)
        1:       w = ($urandom_range(0, 2) == 0);
        2:       w = (j < 20);
        default: w = 1'b0;
      endcase
      pcpi_wait = w;
      if (j == rdy_dly) begin
        pcpi_ready = 1'b1; pcpi_wr = wr; pcpi_rd = rd;
        step;
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_wait = 1'b0;
      end else if (WD && !w && run + 1 == TO) begin
        aborted = 1'b1;
        step;
        pcpi_wait = 1'b0;
        break;
      end else begin
        pcpi_wr = $urandom; pcpi_rd = $urandom;
        run = w ? 0 : run + 1;
        step;
        chk("issue_hold", pcpi_valid, 1);
      end
    end

    if (aborted) begin
      chk("abort_valid", pcpi_valid, 0);
      chk("abort_done", done, 1);
      chk("abort_err", err_timeout, 1);
      chk("abort_no_res", res_valid, 0);
      step;
      chk("abort_ready", cmd_ready, 1);
      chk("abort_done_end", done, 0);
      chk("abort_err_sticky", err_timeout, 1);
      return;
    end

    chk("valid_drop", pcpi_valid, 0);
    if (!wr) begin
      chk("nowr_done", done, 1);
      chk("nowr_no_res", res_valid, 0);
      chk("nowr_ready_lo", cmd_ready, 0);
      step;
      chk("nowr_ready", cmd_ready, 1);
      chk("nowr_done_end", done, 0);
      return;
    end

    for (int i = 0; i < 8; i++) begin
      e = 4'(rd >> (4 * i));
      if (i == rst_nib) begin
        rst_n = 1'b0;
        step;
        chk("rst_pcpi_valid", pcpi_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_done", done, 0);
        chk("rst_insn", pcpi_insn, 0);
        rst_n = 1'b1;
        step;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_idle", res_valid, 0);
        chk("rst_err", err_timeout, 0);
        return;
      end
      for (int s = 0; s < stall[i]; s++) begin
        res_ack = 1'b0;
        pcpi_ready = $urandom; pcpi_wr = $urandom; pcpi_rd = $urandom;
        chk("stall_valid", res_valid, 1);
        chk("stall_nibble", res_nibble, e);
        chk("stall_last", res_last, (i == 7));
        step;
      end
      pcpi_ready = 1'b0; pcpi_wr = 1'b0;
      chk("nib_valid", res_valid, 1);
      chk("nib_value", res_nibble, e);
      chk("nib_last", res_last, (i == 7));
      chk("nib_no_done", done, 0);
      res_ack = 1'b1;
      step;
      res_ack = 1'b0;
    end
    chk("send_done", done, 1);
    chk("send_res_off", res_valid, 0);
    chk("send_pcpi_off", pcpi_valid, 0);
    chk("send_ready_lo", cmd_ready, 0);
    step;
    chk("send_ready", cmd_ready, 1);
    chk("send_done_end", done, 0);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0;
    res_ack = 1'b0;
    foreach (stall[i]) stall[i] = 0;
    @(negedge clk);
    repeat (3) step;
    chk("reset_pcpi_valid", pcpi_valid, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_last", res_last, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err_timeout, 0);
    chk("reset_insn", pcpi_insn, 0);
    chk("reset_rs1", pcpi_rs1, 0);
    rst_n = 1'b1;
    step;
    chk("reset_cmd_ready", cmd_ready, 1);

    // pcpi_ready while idle must be ignored
    pcpi_ready = 1'b1; pcpi_wr = 1'b1;
    step;
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    chk("idle_rdy_valid", pcpi_valid, 0);
    chk("idle_rdy_res", res_valid, 0);
    chk("idle_rdy_done", done, 0);

    run_txn(32'h0000_000B, 32'd3, 32'd5, 4, 1'b1, 32'h8765_4321, 0, -1);
    stall[2] = 5;
    run_txn(32'h0000_000B, 32'd3, 32'd5, 4, 1'b1, 32'h8765_4321, 0, -1);
    stall[2] = 0;
    run_txn(32'h0200_000B, 32'd7, 32'd9, 2, 1'b0, 32'h0, 0, -1);
`ifdef PCPI_TIMEOUT_EN
    run_txn(32'h0000_100B, 32'd1, 32'd2, 1000, 1'b1, 32'hDEAD_BEEF, 0, -1);
    run_txn(32'h0000_200B, 32'd4, 32'd6, TO - 1, 1'b1, 32'hCAFE_F00D, 0, -1);
`endif
    run_txn(32'h0000_300B, 32'd8, 32'd9, 21, 1'b1, 32'h1357_9BDF, 2, -1);
    run_txn(32'h0000_400B, 32'd5, 32'd5, 3, 1'b1, 32'hFEDC_BA98, 0, 4);

    for (int k = 0; k < 40; k++) begin
      foreach (stall[i]) stall[i] = $urandom_range(0, 2);
      run_txn($urandom, $urandom, $urandom, $urandom_range(0, 15),
              ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
